pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: button synchronizers, serve/play/point/game-over flow, scoring and paddle move requests.
// Optional PAUSE state is compiled in when PONG_PAUSE_EN is defined.
module pong_game_ctrl #(
    parameter int MOVE_DIV     = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frameTick,
    input  logic       startButton,
    input  logic       p1UpButton,
    input  logic       p1DownButton,
    input  logic       p2UpButton,
    input  logic       p2DownButton,
    input  logic       ballMissLeft,
    input  logic       ballMissRight,
    output logic       p1Up,
    output logic       p1Down,
    output logic       p2Up,
    output logic       p2Down,
    output logic       ballEnable,
    output logic       ballReset,
    output logic       serveDir,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [2:0] gameState,
    output logic [1:0] winner
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SERVE    = 3'd1;
    localparam logic [2:0] PLAY     = 3'd2;
    localparam logic [2:0] POINT    = 3'd3;
    localparam logic [2:0] GAMEOVER = 3'd4;
    localparam logic [2:0] PAUSE    = 3'd5;

    localparam logic [3:0] MOVE_LAST  = 4'(MOVE_DIV - 1);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    // Button vector order: {start, p1Up, p1Down, p2Up, p2Down}; raw level 0 means pressed.
    logic [4:0] btnMeta, btnSync, btnPrev, held, press;
    logic [3:0] moveCnt;
    logic       moveStrobe, paddleActive;
    logic [2:0] state, stateNext;
    logic [7:0] frameCnt, frameCntNext;
    logic [3:0] score1Next, score2Next;
    logic [1:0] winnerNext;
    logic       serveDirNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btnMeta <= '1;
            btnSync <= '1;
            btnPrev <= '1;
        end else begin
            btnMeta <= {startButton, p1UpButton, p1DownButton, p2UpButton, p2DownButton};
            btnSync <= btnMeta;
            btnPrev <= btnSync;
        end
    end

    assign held  = ~btnSync;
    assign press = btnPrev & ~btnSync;

    assign moveStrobe = frameTick && (moveCnt == MOVE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          moveCnt <= '0;
        else if (frameTick) moveCnt <= moveStrobe ? 4'd0 : moveCnt + 4'd1;
    end

    always_comb begin
        // NOTE: every next-value starts from its hold value so no path can infer a latch.
        stateNext    = state;
        frameCntNext = frameCnt;
        score1Next   = score1;
        score2Next   = score2;
        winnerNext   = winner;
        serveDirNext = serveDir;
        case (state)
            IDLE, GAMEOVER: begin
                if (press[4]) begin
                    stateNext  = SERVE;
                    score1Next = '0;
                    score2Next = '0;
                    winnerNext = '0;
                    if (state == IDLE) serveDirNext = 1'b0;
                end
            end
            SERVE: begin
                if (frameTick) begin
                    if (frameCnt == SERVE_LAST) stateNext = PLAY;
                    else                        frameCntNext = frameCnt + 8'd1;
                end
            end
            PLAY: begin
                if (ballMissLeft && ballMissRight) begin
                    stateNext = POINT;
                end else if (ballMissLeft) begin
                    if (score2 < WIN) score2Next = score2 + 4'd1;
                    serveDirNext = 1'b0;
                    stateNext    = POINT;
                end else if (ballMissRight) begin
                    if (score1 < WIN) score1Next = score1 + 4'd1;
                    serveDirNext = 1'b1;
                    stateNext    = POINT;
                end
`ifdef PONG_PAUSE_EN
                else if (press[4]) begin
                    stateNext = PAUSE;
                end
`endif
            end
            POINT: begin
                if (frameTick) begin
                    if (frameCnt == POINT_LAST) begin
                        if (score1 == WIN) begin
                            stateNext  = GAMEOVER;
                            winnerNext = 2'd1;
                        end else if (score2 == WIN) begin
                            stateNext  = GAMEOVER;
                            winnerNext = 2'd2;
                        end else begin
                            stateNext = SERVE;
                        end
                    end else begin
                        frameCntNext = frameCnt + 8'd1;
                    end
                end
            end
`ifdef PONG_PAUSE_EN
            PAUSE: if (press[4]) stateNext = PLAY;
`else
            PAUSE: stateNext = IDLE;
`endif
            default: stateNext = IDLE;
        endcase
        // Frame count never carries across a state change.
        if (stateNext != state) frameCntNext = '0;
    end

    assign paddleActive = (state == SERVE) || (state == PLAY);
    assign gameState    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            frameCnt   <= '0;
            score1     <= '0;
            score2     <= '0;
            winner     <= '0;
            serveDir   <= 1'b0;
            ballEnable <= 1'b0;
            ballReset  <= 1'b1;
            p1Up       <= 1'b1;
            p1Down     <= 1'b1;
            p2Up       <= 1'b1;
            p2Down     <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
            state      <= stateNext;
            frameCnt   <= frameCntNext;
            score1     <= score1Next;
            score2     <= score2Next;
            winner     <= winnerNext;
            serveDir   <= serveDirNext;
            ballEnable <= (stateNext == PLAY);
            ballReset  <= (stateNext != PLAY) && (stateNext != PAUSE);
            p1Up       <= ~(moveStrobe && paddleActive && held[3] && !held[2]);
            p1Down     <= ~(moveStrobe && paddleActive && held[2] && !held[3]);
            p2Up       <= ~(moveStrobe && paddleActive && held[1] && !held[0]);
            p2Down     <= ~(moveStrobe && paddleActive && held[0] && !held[1]);
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl (MOVE_DIV=2, SERVE_FRAMES=3, POINT_FRAMES=4, WIN_SCORE=2).
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frameTick = 1'b0;
    logic       startButton = 1'b1;
    logic       p1UpButton = 1'b1, p1DownButton = 1'b1, p2UpButton = 1'b1, p2DownButton = 1'b1;
    logic       ballMissLeft = 1'b0, ballMissRight = 1'b0;
    logic       p1Up, p1Down, p2Up, p2Down;
    logic       ballEnable, ballReset, serveDir;
    logic [3:0] score1, score2;
    logic [2:0] gameState;
    logic [1:0] winner;

    int vectors = 0;
    int miscompares = 0;
    int cntP1Up, cntP1Down, cntP2Up, cntP2Down, longPulses;
    logic [3:0] prevPad;

    pong_game_ctrl #(
        .MOVE_DIV(2), .SERVE_FRAMES(3), .POINT_FRAMES(4), .WIN_SCORE(2)
    ) dut (
        .clk(clk), .reset(reset), .frameTick(frameTick), .startButton(startButton),
        .p1UpButton(p1UpButton), .p1DownButton(p1DownButton),
        .p2UpButton(p2UpButton), .p2DownButton(p2DownButton),
        .ballMissLeft(ballMissLeft), .ballMissRight(ballMissRight),
        .p1Up(p1Up), .p1Down(p1Down), .p2Up(p2Up), .p2Down(p2Down),
        .ballEnable(ballEnable), .ballReset(ballReset), .serveDir(serveDir),
        .score1(score1), .score2(score2), .gameState(gameState), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic clearCounts();
        cntP1Up = 0; cntP1Down = 0; cntP2Up = 0; cntP2Down = 0; longPulses = 0;
        prevPad = 4'hF;
    endtask

    task automatic samplePads();
        logic [3:0] pad;
        pad = {p1Up, p1Down, p2Up, p2Down};
        if (!p1Up)   cntP1Up++;
        if (!p1Down) cntP1Down++;
        if (!p2Up)   cntP2Up++;
        if (!p2Down) cntP2Down++;
        if ((~pad & ~prevPad) != 4'h0) longPulses++;
        prevPad = pad;
    endtask

    // Each frame lasts 4 clocks with frameTick high for the first one.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                samplePads();
                frameTick = (k == 0);
            end
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pressStart();
        @(negedge clk);
        startButton = 1'b0;
        waitClks(5);
        startButton = 1'b1;
        waitClks(5);
    endtask

    task automatic missPulse(input logic left, input logic right);
        @(negedge clk);
        ballMissLeft  = left;
        ballMissRight = right;
        @(negedge clk);
        ballMissLeft  = 1'b0;
        ballMissRight = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        waitClks(3);
        vectors++;
        if (gameState !== 3'd0 || score1 !== 4'd0 || score2 !== 4'd0 || winner !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: state=%0d s1=%0d s2=%0d win=%0d, need 0/0/0/0", gameState, score1, score2, winner);
        end
        vectors++;
        if (ballEnable !== 1'b0 || ballReset !== 1'b1 || serveDir !== 1'b0 ||
            {p1Up, p1Down, p2Up, p2Down} !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_outputs: en=%b rst=%b dir=%b pads=%b, need 0 1 0 1111",
                     ballEnable, ballReset, serveDir, {p1Up, p1Down, p2Up, p2Down});
        end
        reset = 1'b0;
        waitClks(2);
    endtask

    task automatic test_idle_ignores();
        missPulse(1'b1, 1'b1);
        clearCounts();
        p1UpButton = 1'b0;
        waitClks(4);
        frames(4);
        p1UpButton = 1'b1;
        waitClks(4);
        vectors++;
        if (gameState !== 3'd0 || score1 !== 4'd0 || score2 !== 4'd0 || cntP1Up !== 0) begin
            miscompares++;
            $display("FAIL idle_ignore: state=%0d s1=%0d s2=%0d p1UpPulses=%0d, need 0/0/0/0",
                     gameState, score1, score2, cntP1Up);
        end
    endtask

    task automatic test_serve();
        pressStart();
        vectors++;
        if (gameState !== 3'd1 || ballReset !== 1'b1 || ballEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL serve_entry: state=%0d rst=%b en=%b, need 1 1 0", gameState, ballReset, ballEnable);
        end
        frames(2);
        vectors++;
        if (gameState !== 3'd1 || ballReset !== 1'b1) begin
            miscompares++;
            $display("FAIL serve_hold: state=%0d rst=%b after 2 ticks, need 1 1", gameState, ballReset);
        end
        frames(1);
        vectors++;
        if (gameState !== 3'd2 || ballEnable !== 1'b1 || ballReset !== 1'b0) begin
            miscompares++;
            $display("FAIL serve_to_play: state=%0d en=%b rst=%b, need 2 1 0", gameState, ballEnable, ballReset);
        end
    endtask

    task automatic test_paddles();
        clearCounts();
        p1UpButton = 1'b0;
        waitClks(4);
        frames(10);
        p1UpButton = 1'b1;
        waitClks(4);
        vectors++;
        if (cntP1Up !== 5 || cntP1Down !== 0 || cntP2Up !== 0 || cntP2Down !== 0 || longPulses !== 0) begin
            miscompares++;
            $display("FAIL p1_up_move: up=%0d down=%0d p2=%0d/%0d long=%0d, need 5 0 0/0 0",
                     cntP1Up, cntP1Down, cntP2Up, cntP2Down, longPulses);
        end
        clearCounts();
        p2DownButton = 1'b0;
        waitClks(4);
        frames(4);
        p2DownButton = 1'b1;
        waitClks(4);
        vectors++;
        if (cntP2Down !== 2 || cntP2Up !== 0 || cntP1Up !== 0 || longPulses !== 0) begin
            miscompares++;
            $display("FAIL p2_down_move: down=%0d up=%0d p1Up=%0d long=%0d, need 2 0 0 0",
                     cntP2Down, cntP2Up, cntP1Up, longPulses);
        end
        clearCounts();
        p1UpButton = 1'b0;
        p1DownButton = 1'b0;
        waitClks(4);
        frames(10);
        p1UpButton = 1'b1;
        p1DownButton = 1'b1;
        waitClks(4);
        vectors++;
        if (cntP1Up !== 0 || cntP1Down !== 0) begin
            miscompares++;
            $display("FAIL both_held: up=%0d down=%0d, need 0 0", cntP1Up, cntP1Down);
        end
        vectors++;
        if (gameState !== 3'd2) begin
            miscompares++;
            $display("FAIL play_stays: state=%0d, need 2", gameState);
        end
    endtask

    task automatic test_score_and_win();
        missPulse(1'b0, 1'b1);
        vectors++;
        if (score1 !== 4'd1 || score2 !== 4'd0 || gameState !== 3'd3 || serveDir !== 1'b1 || ballEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL miss_right: s1=%0d s2=%0d state=%0d dir=%b en=%b, need 1 0 3 1 0",
                     score1, score2, gameState, serveDir, ballEnable);
        end
        missPulse(1'b1, 1'b0);
        frames(3);
        vectors++;
        if (score2 !== 4'd0 || gameState !== 3'd3) begin
            miscompares++;
            $display("FAIL point_hold: s2=%0d state=%0d, need 0 3", score2, gameState);
        end
        frames(1);
        vectors++;
        if (gameState !== 3'd1) begin
            miscompares++;
            $display("FAIL point_to_serve: state=%0d, need 1", gameState);
        end
        frames(3);
        missPulse(1'b0, 1'b1);
        vectors++;
        if (score1 !== 4'd2 || gameState !== 3'd3) begin
            miscompares++;
            $display("FAIL second_point: s1=%0d state=%0d, need 2 3", score1, gameState);
        end
        frames(4);
        vectors++;
        if (gameState !== 3'd4 || winner !== 2'd1 || serveDir !== 1'b1 || ballReset !== 1'b1 || ballEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL game_over: state=%0d win=%0d dir=%b rst=%b en=%b, need 4 1 1 1 0",
                     gameState, winner, serveDir, ballReset, ballEnable);
        end
        pressStart();
        vectors++;
        if (gameState !== 3'd1 || score1 !== 4'd0 || score2 !== 4'd0 || winner !== 2'd0) begin
            miscompares++;
            $display("FAIL restart: state=%0d s1=%0d s2=%0d win=%0d, need 1 0 0 0", gameState, score1, score2, winner);
        end
    endtask

    task automatic test_double_miss();
        frames(3);
        missPulse(1'b1, 1'b1);
        vectors++;
        if (score1 !== 4'd0 || score2 !== 4'd0 || gameState !== 3'd3 || serveDir !== 1'b1) begin
            miscompares++;
            $display("FAIL double_miss: s1=%0d s2=%0d state=%0d dir=%b, need 0 0 3 1",
                     score1, score2, gameState, serveDir);
        end
        frames(4);
        frames(3);
        missPulse(1'b1, 1'b0);
        vectors++;
        if (score2 !== 4'd1 || score1 !== 4'd0 || serveDir !== 1'b0 || gameState !== 3'd3) begin
            miscompares++;
            $display("FAIL miss_left: s1=%0d s2=%0d dir=%b state=%0d, need 0 1 0 3",
                     score1, score2, serveDir, gameState);
        end
        frames(4);
        frames(3);
    endtask

    task automatic test_pause();
        pressStart();
`ifdef PONG_PAUSE_EN
        vectors++;
        if (gameState !== 3'd5 || ballEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL pause_entry: state=%0d en=%b, need 5 0", gameState, ballEnable);
        end
        missPulse(1'b1, 1'b0);
        vectors++;
        if (score2 !== 4'd1 || gameState !== 3'd5) begin
            miscompares++;
            $display("FAIL pause_miss: s2=%0d state=%0d, need 1 5", score2, gameState);
        end
        pressStart();
`endif
        vectors++;
        if (gameState !== 3'd2 || ballEnable !== 1'b1) begin
            miscompares++;
            $display("FAIL start_in_play: state=%0d en=%b, need 2 1", gameState, ballEnable);
        end
    endtask

    task automatic test_reset_midgame();
        vectors++;
        if (score2 !== 4'd1 || gameState !== 3'd2) begin
            miscompares++;
            $display("FAIL pre_reset: s2=%0d state=%0d, need 1 2", score2, gameState);
        end
        p1UpButton = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (gameState !== 3'd0 || score1 !== 4'd0 || score2 !== 4'd0 || ballReset !== 1'b1 ||
            ballEnable !== 1'b0 || {p1Up, p1Down, p2Up, p2Down} !== 4'hF) begin
            miscompares++;
            $display("FAIL midgame_reset: state=%0d s1=%0d s2=%0d rst=%b en=%b pads=%b, need 0 0 0 1 0 1111",
                     gameState, score1, score2, ballReset, ballEnable, {p1Up, p1Down, p2Up, p2Down});
        end
        reset = 1'b0;
        clearCounts();
        frames(4);
        p1UpButton = 1'b1;
        vectors++;
        if (gameState !== 3'd0 || cntP1Up !== 0) begin
            miscompares++;
            $display("FAIL post_reset_idle: state=%0d p1UpPulses=%0d, need 0 0", gameState, cntP1Up);
        end
    endtask

    initial begin
        clearCounts();
        test_reset();
        test_idle_ignores();
        test_serve();
        test_paddles();
        test_score_and_win();
        test_double_miss();
        test_pause();
        test_reset_midgame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
